// File: rtl/serial_operand_serializer_using_fsm_pkg.sv
// Shared types and sizing helpers for the serial operand serializer.
package serial_pkg;

    // One-bit FSM state: idle or a word in flight.
    typedef enum logic {
        st_idle  = 1'b0,
        st_shift = 1'b1
    } serial_state_t;

    localparam int SERIAL_W_DEFAULT = 8;

    // Bit-counter width for a W-bit word; a W of 2 still needs one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_operand_serializer_using_fsm_if.sv
// Operand handshake plus serial output bundle of the serializer.
interface serial_operand_serializer_using_fsm_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_a;
    logic         out_b;
    logic         out_first;
    logic         out_last;

    // Producer of operands and consumer of the serial streams.
    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, out_valid, out_a, out_b, out_first, out_last
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, out_valid, out_a, out_b, out_first, out_last
    );
endinterface

// File: rtl/serial_operand_serializer_using_fsm_shift_reg.sv
// Loadable shift register that presents its next outgoing bit on head.
module serial_shift_reg #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         head
);
    logic [W-1:0] sr;

    // Load a fresh operand, otherwise move the next bit toward the head.
    always_ff @(posedge clk) begin
        // NOTE: the register is cleared on reset so an idle block holds a known all-zero word.
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
            sr <= din;
        end else if (shift_en) begin
            sr <= MSB_FIRST ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};
        end
    end

    assign head = MSB_FIRST ? sr[W-1] : sr[0];
endmodule

// File: rtl/serial_operand_serializer_using_fsm.sv
// Parallel-to-serial operand transmitter with first/last framing and
// back-to-back word support.
module serial_operand_serializer_using_fsm
    import serial_pkg::*;
#(
    parameter int W         = SERIAL_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    serial_operand_serializer_using_fsm_if.slave bus
);
    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    if (W < 2) begin : g_w_check
        $error("serial_operand_serializer_using_fsm: W must be at least 2");
    end

    serial_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load, shift_en, xfer;
    logic          head_a, head_b;

    // Ready when idle or on the final bit, so the next word follows without a gap.
    assign bus.in_ready = rst && ((state == st_idle) || (state == st_shift && cnt == CNT_LAST));
    assign xfer         = bus.in_valid && bus.in_ready;

    // State and bit-counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= st_idle;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and shift-register control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift_en  = 1'b0;
        unique case (state)
            st_idle: begin
                if (xfer) begin
                    state_nxt = st_shift;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                end
            end
            st_shift: begin
                if (cnt != CNT_LAST) begin
                    cnt_nxt  = cnt + 1'b1;
                    shift_en = 1'b1;
                end else if (xfer) begin
                    cnt_nxt = '0;
                    load    = 1'b1;
                end else begin
                    state_nxt = st_idle;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = st_idle;
                cnt_nxt   = '0;
            end
        endcase
    end

    serial_shift_reg #(.W(W), .MSB_FIRST(MSB_FIRST)) u_sr_a (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (bus.in_a),
        .head     (head_a)
    );

    serial_shift_reg #(.W(W), .MSB_FIRST(MSB_FIRST)) u_sr_b (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (bus.in_b),
        .head     (head_b)
    );

    // Outputs depend on registers only; data bits read 0 outside a word.
    assign bus.out_valid = (state == st_shift);
    assign bus.out_a     = bus.out_valid && head_a;
    assign bus.out_b     = bus.out_valid && head_b;
    assign bus.out_first = bus.out_valid && (cnt == '0);
    assign bus.out_last  = bus.out_valid && (cnt == CNT_LAST);
endmodule

// File: tb/tb_serial_operand_serializer_using_fsm.sv
// Directed bench: an MSB-first and an LSB-first serializer driven in parallel.
module tb_serial_operand_serializer_using_fsm;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_operand_serializer_using_fsm_if #(.W(8)) bus_m ();
    serial_operand_serializer_using_fsm_if #(.W(8)) bus_l ();

    serial_operand_serializer_using_fsm #(.W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    serial_operand_serializer_using_fsm #(.W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    typedef struct {
        logic       iv;
        logic [7:0] ia;
        logic [7:0] ib;
        logic       ev;
        logic       er;
        logic       ef;
        logic       el;
        logic       eam;
        logic       ebm;
        logic       eal;
        logic       ebl;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus_m.in_valid = v;
        bus_m.in_a     = a;
        bus_m.in_b     = b;
        bus_l.in_valid = v;
        bus_l.in_a     = a;
        bus_l.in_b     = b;
    endtask

    function automatic vec_t mk(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                                input logic ev, input logic er, input logic ef, input logic el,
                                input logic am, input logic bm, input logic al, input logic bl);
        vec_t v;
        v.iv = iv; v.ia = ia; v.ib = ib;
        v.ev = ev; v.er = er; v.ef = ef; v.el = el;
        v.eam = am; v.ebm = bm; v.eal = al; v.ebl = bl;
        return v;
    endfunction

    initial begin
        // Expected serial sequences, leftmost character is the first bit on the wire.
        logic [7:0] sam1, sbm1, sal1, sbl1, sam2, sbm2, sal2, sbl2;
        logic [7:0] s5a, sa5, sc3, s96;
        logic [7:0] wa[3];
        logic [7:0] wb[3];
        logic       xfer, decided, gt;
        int         k;

        sam1 = 8'b10100101; sbm1 = 8'b00111100;   // A5 / 3C, MSB first
        sal1 = 8'b10100101; sbl1 = 8'b00111100;   // A5 / 3C, LSB first
        sam2 = 8'b00000001; sbm2 = 8'b10000000;   // 01 / 80, MSB first
        sal2 = 8'b10000000; sbl2 = 8'b00000001;   // 01 / 80, LSB first
        s5a  = 8'b01011010;
        sa5  = 8'b10100101;
        sc3  = 8'b11000011;
        s96  = 8'b10010110;

        vecs[0] = mk(1'b1, 8'hA5, 8'h3C, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            vecs[1+i] = mk(1'b0, 8'h00, 8'h00, 1, (i == 7), (i == 0), (i == 7),
                           sam1[7-i], sbm1[7-i], sal1[7-i], sbl1[7-i]);
        vecs[9] = mk(1'b1, 8'h01, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            vecs[10+i] = mk(1'b0, 8'h00, 8'h00, 1, (i == 7), (i == 0), (i == 7),
                            sam2[7-i], sbm2[7-i], sal2[7-i], sbl2[7-i]);
        vecs[18] = mk(1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset: outputs quiet, in_ready forced low while rst is low.
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_m", 16'({bus_m.out_valid, bus_m.out_a, bus_m.out_b, bus_m.out_first, bus_m.out_last}), 16'h0);
        check("reset_outputs_l", 16'({bus_l.out_valid, bus_l.out_a, bus_l.out_b, bus_l.out_first, bus_l.out_last}), 16'h0);
        check("reset_ready_low", 16'(bus_m.in_ready), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table: two single words, both bit orders checked per cycle.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].ia, vecs[i].ib);
            @(negedge clk);
            check($sformatf("vec%0d_msb", i),
                  16'({bus_m.out_valid, bus_m.in_ready, bus_m.out_first, bus_m.out_last, bus_m.out_a, bus_m.out_b}),
                  16'({vecs[i].ev, vecs[i].er, vecs[i].ef, vecs[i].el, vecs[i].eam, vecs[i].ebm}));
            check($sformatf("vec%0d_lsb", i),
                  16'({bus_l.out_valid, bus_l.in_ready, bus_l.out_first, bus_l.out_last, bus_l.out_a, bus_l.out_b}),
                  16'({vecs[i].ev, vecs[i].er, vecs[i].ef, vecs[i].el, vecs[i].eal, vecs[i].ebl}));
            @(posedge clk);
            #1;
        end

        // Streaming: three words with in_valid held, no bubble.
        wa[0] = 8'hF0; wb[0] = 8'h0F;
        wa[1] = 8'h5A; wb[1] = 8'hC3;
        wa[2] = 8'h81; wb[2] = 8'h18;
        k = 0;
        for (int c = 0; c < 26; c++) begin
            if (k < 3) drive(1'b1, wa[k], wb[k]);
            else       drive(1'b0, 8'h00, 8'h00);
            @(negedge clk);
            check($sformatf("stream_valid_c%0d", c), 16'(bus_m.out_valid), 16'(c >= 1 && c <= 24));
            check($sformatf("stream_ready_c%0d", c), 16'(bus_m.in_ready), 16'(c == 0 || c == 8 || c == 16 || c >= 24));
            check($sformatf("stream_first_c%0d", c), 16'(bus_m.out_first), 16'(c == 1 || c == 9 || c == 17));
            if (c >= 9 && c <= 16)
                check($sformatf("stream_a_c%0d", c), 16'(bus_m.out_a), 16'(s5a[16-c]));
            xfer = bus_m.in_valid && bus_m.in_ready;
            @(posedge clk);
            #1;
            if (xfer) k++;
        end
        check("stream_words", 16'(k), 16'd3);

        // Early in_valid mid-word: held off until the last bit, first word intact.
        k = 0;
        for (int c = 0; c < 18; c++) begin
            if (k == 0)                drive(1'b1, 8'hA5, 8'h3C);
            else if (k == 1 && c >= 3) drive(1'b1, 8'hC3, 8'h81);
            else                       drive(1'b0, 8'h00, 8'h00);
            @(negedge clk);
            check($sformatf("hold_ready_c%0d", c), 16'(bus_m.in_ready), 16'(c == 0 || c == 8 || c >= 16));
            check($sformatf("hold_first_c%0d", c), 16'(bus_m.out_first), 16'(c == 1 || c == 9));
            if (c >= 1 && c <= 8)
                check($sformatf("hold_a_c%0d", c), 16'(bus_m.out_a), 16'(sa5[8-c]));
            else if (c >= 9 && c <= 16)
                check($sformatf("hold_a_c%0d", c), 16'(bus_m.out_a), 16'(sc3[16-c]));
            else
                check($sformatf("hold_a_c%0d", c), 16'(bus_m.out_a), 16'h0);
            xfer = bus_m.in_valid && bus_m.in_ready;
            @(posedge clk);
            #1;
            if (xfer) k++;
        end

        // Reset during bit 4 of a word: word dropped, next word starts cleanly.
        for (int c = 0; c < 15; c++) begin
            rst = (c == 4) ? 1'b0 : 1'b1;
            if (c == 0)      drive(1'b1, 8'hA5, 8'h3C);
            else if (c == 5) drive(1'b1, 8'h96, 8'h69);
            else             drive(1'b0, 8'h00, 8'h00);
            @(negedge clk);
            check($sformatf("rst_valid_c%0d", c), 16'(bus_m.out_valid), 16'((c >= 1 && c <= 4) || (c >= 6 && c <= 13)));
            check($sformatf("rst_ready_c%0d", c), 16'(bus_m.in_ready), 16'(c == 0 || c == 5 || c >= 13));
            check($sformatf("rst_frame_c%0d", c), 16'({bus_m.out_first, bus_m.out_last}),
                  16'({(c == 1 || c == 6), (c == 13)}));
            if (c >= 1 && c <= 4)
                check($sformatf("rst_a_c%0d", c), 16'(bus_m.out_a), 16'(sa5[8-c]));
            else if (c >= 6 && c <= 13)
                check($sformatf("rst_a_c%0d", c), 16'(bus_m.out_a), 16'(s96[13-c]));
            else
                check($sformatf("rst_ab_c%0d", c), 16'({bus_m.out_a, bus_m.out_b}), 16'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        // MSB-first serial comparator restarted on out_first; stale state preset to "greater".
        decided = 1'b1;
        gt      = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) drive(1'b1, 8'h64, 8'h62);
            else        drive(1'b0, 8'h00, 8'h00);
            @(negedge clk);
            if (bus_m.out_valid) begin
                if (bus_m.out_first) begin
                    decided = 1'b0;
                    gt      = 1'b0;
                end
                if (!decided && (bus_m.out_a != bus_m.out_b)) begin
                    decided = 1'b1;
                    gt      = bus_m.out_a;
                end
                check($sformatf("cmp_greater_c%0d", c), 16'(gt), 16'(c >= 6));
            end else begin
                check($sformatf("cmp_idle_c%0d", c), 16'(c), 16'd0);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
